// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
// Shares the single OTTER memory port between instruction fetch (IF) and
// data load/store (D). One transaction is outstanding at a time; the
// registered response is routed back to the requester that owns it.
// D wins arbitration, but after MAX_STREAK consecutive D grants while IF
// is waiting, IF is served next.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   if_req_i, if_addr_i           fetch request (held until if_gnt_o)
//   if_gnt_o                      fetch accepted this cycle
//   if_rvalid_o, if_rdata_o       one-cycle fetch response pulse + word
//   d_req_i, d_we_i, d_be_i,      data request (held until d_gnt_o)
//   d_addr_i, d_wdata_i
//   d_gnt_o                       data request accepted this cycle
//   d_rvalid_o, d_rdata_o         one-cycle data response; rdata 0 for stores
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o       request to memory, fields of selected requester
//   mem_ready_i                   memory accepts the request this cycle
//   mem_rvalid_i, mem_rdata_i     completion of the outstanding transaction
//   busy_o                        a transaction is outstanding
module otter_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       streak_q, streak_d;
    logic                store_q, store_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic sel_d, sel_if;

    // D is preferred unless IF is waiting and D has used up its streak.
    assign sel_d  = d_req_i && (!if_req_i || (streak_q < STREAK_MAX));
    assign sel_if = if_req_i && !sel_d;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        store_d     = store_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                mem_req_o = if_req_i | d_req_i;
                if (sel_d) begin
                    mem_we_o    = d_we_i;
                    mem_be_o    = d_be_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                end else if (sel_if) begin
                    // Fetch is always a full-word read.
                    mem_addr_o = if_addr_i;
                    mem_be_o   = '1;
                end

                if (mem_ready_i) begin
                    if (sel_d) begin
                        d_gnt_o  = 1'b1;
                        state_d  = WAIT_D;
                        store_d  = d_we_i;
                        // Streak only counts D grants that made IF wait.
                        if (if_req_i) begin
                            if (streak_q < STREAK_MAX) begin
                                streak_d = streak_q + 1'b1;
                            end
                        end else begin
                            streak_d = '0;
                        end
                    end else if (sel_if) begin
                        if_gnt_o = 1'b1;
                        state_d  = WAIT_IF;
                        streak_d = '0;
                    end
                end
            end
            WAIT_IF: begin
                if (mem_rvalid_i) begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata_i;
                    state_d     = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rvalid_i) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = store_q ? '0 : mem_rdata_i;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            store_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            store_q     <= store_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Testbench for otter_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model of the arbiter held in this bench.
module tb_otter_mem_arbiter;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    // memory model drive
    logic        rand_ready, mem_rvalid_r, spur_pulse;
    logic [31:0] mem_rdata_r, spur_data;
    int          ready_mode;     // 0 random, 1 always ready, 2 never ready
    bit          mem_pending, acc, fixed_en;
    int          mem_cnt, lat_min, lat_max;
    logic [31:0] fixed_val;

    assign mem_ready  = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 : rand_ready;
    assign mem_rvalid = mem_rvalid_r | spur_pulse;
    assign mem_rdata  = spur_pulse ? spur_data : mem_rdata_r;

    otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model: owner 0 = none outstanding, 1 = IF, 2 = D
    int          m_owner, m_streak;
    bit          m_store, m_if_rv, m_d_rv;
    logic [31:0] m_if_rd, m_d_rd;

    // snapshot of DUT outputs taken mid-cycle
    logic        s_if_gnt, s_d_gnt, s_if_rv, s_d_rv, s_busy, s_mem_req, s_mem_we;
    logic [31:0] s_if_rd, s_d_rd, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_streak = 0; m_store = 0;
        m_if_rv = 0; m_d_rv = 0; m_if_rd = '0; m_d_rd = '0;
    endtask

    task automatic model_check();
        bit   pick_d, pick_if, gnt;
        logic e_req;
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            model_reset();
            return;
        end
        chk("busy", 32'(busy), 32'(m_owner != 0));
        chk("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
        chk("if_rdata", if_rdata, m_if_rd);
        chk("d_rvalid", 32'(d_rvalid), 32'(m_d_rv));
        chk("d_rdata", d_rdata, m_d_rd);
        if (m_if_rv) $display("txn IF response data=0x%08h @%0t", m_if_rd, $time);
        if (m_d_rv)  $display("txn D  response data=0x%08h @%0t", m_d_rd, $time);

        pick_d = 0; pick_if = 0; e_req = 0;
        if (m_owner == 0) begin
            e_req   = if_req | d_req;
            pick_d  = d_req && (!if_req || m_streak < MS);
            pick_if = if_req && !pick_d;
        end
        gnt = (pick_d || pick_if) && mem_ready;
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("if_gnt", 32'(if_gnt), 32'(pick_if && mem_ready));
        chk("d_gnt", 32'(d_gnt), 32'(pick_d && mem_ready));
        if (pick_d) begin
            chk("mem_addr_d", mem_addr, d_addr);
            chk("mem_we_d", 32'(mem_we), 32'(d_we));
            chk("mem_be_d", 32'(mem_be), 32'(d_be));
            chk("mem_wdata_d", mem_wdata, d_wdata);
        end else if (pick_if) begin
            chk("mem_addr_if", mem_addr, if_addr);
            chk("mem_we_if", 32'(mem_we), 32'd0);
        end else begin
            chk("mem_addr_0", mem_addr, 32'd0);
            chk("mem_we_0", 32'(mem_we), 32'd0);
            chk("mem_be_0", 32'(mem_be), 32'd0);
            chk("mem_wdata_0", mem_wdata, 32'd0);
        end

        m_if_rv = 0; m_d_rv = 0;
        if (m_owner == 0) begin
            if (gnt && pick_d) begin
                m_owner  = 2;
                m_store  = d_we;
                m_streak = if_req ? ((m_streak + 1 > MS) ? MS : m_streak + 1) : 0;
            end else if (gnt) begin
                m_owner  = 1;
                m_streak = 0;
            end
        end else if (mem_rvalid) begin
            if (m_owner == 1) begin
                m_if_rv = 1; m_if_rd = mem_rdata;
            end else begin
                m_d_rv = 1; m_d_rd = m_store ? 32'd0 : mem_rdata;
            end
            m_owner = 0;
        end
    endtask

    // One clock cycle: check at the falling edge, then update the memory
    // model just after the rising edge. Returns at posedge+1.
    task automatic tick();
        @(negedge clk);
        model_check();
        s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rv = if_rvalid; s_d_rv = d_rvalid;
        s_if_rd = if_rdata; s_d_rd = d_rdata; s_busy = busy; s_mem_req = mem_req;
        s_mem_we = mem_we; s_mem_be = mem_be; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
        acc = rst_n && mem_req && mem_ready;
        @(posedge clk);
        #1;
        spur_pulse   = 1'b0;
        mem_rvalid_r = 1'b0;
        if (!rst_n) begin
            mem_pending = 0;
        end else begin
            if (acc) begin
                mem_pending = 1;
                mem_cnt = int'($urandom_range(lat_max, lat_min));
            end
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_rvalid_r = 1'b1;
                    mem_pending  = 0;
                end
            end
        end
        mem_rdata_r = fixed_en ? fixed_val : $urandom();
        rand_ready  = ($urandom_range(3, 0) != 0);
    endtask

    initial begin
        int ng;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        rand_ready = 1; mem_rvalid_r = 0; spur_pulse = 0; mem_rdata_r = '0; spur_data = '0;
        ready_mode = 1; mem_pending = 0; acc = 0; mem_cnt = 0; lat_min = 1; lat_max = 1;
        fixed_en = 1; fixed_val = 32'h0000_0013;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // single fetch, latency 1
        if_req = 1; if_addr = 32'h0000_0040;
        tick();
        chk("fetch_gnt", 32'(s_if_gnt), 32'd1);
        chk("fetch_mem_addr", s_mem_addr, 32'h40);
        chk("fetch_mem_req", 32'(s_mem_req), 32'd1);
        if_req = 0;
        tick();
        chk("fetch_busy_n1", 32'(s_busy), 32'd1);
        chk("fetch_rvalid_n1", 32'(s_if_rv), 32'd0);
        tick();
        chk("fetch_rvalid_n2", 32'(s_if_rv), 32'd1);
        chk("fetch_rdata_n2", s_if_rd, 32'h13);
        chk("fetch_busy_n2", 32'(s_busy), 32'd0);

        // store: completion returns zero data
        fixed_val = 32'h5555_AAAA;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h1100_0020; d_wdata = 32'hABCD_1234;
        tick();
        chk("store_gnt", 32'(s_d_gnt), 32'd1);
        chk("store_mem_we", 32'(s_mem_we), 32'd1);
        chk("store_mem_be", 32'(s_mem_be), 32'h3);
        chk("store_mem_addr", s_mem_addr, 32'h1100_0020);
        chk("store_mem_wdata", s_mem_wdata, 32'hABCD_1234);
        d_req = 0;
        tick();
        tick();
        chk("store_rvalid", 32'(s_d_rv), 32'd1);
        chk("store_rdata", s_d_rd, 32'd0);
        chk("store_if_rvalid", 32'(s_if_rv), 32'd0);
        chk("store_if_rdata_hold", s_if_rd, 32'h13);

        // spurious completion while idle
        spur_pulse = 1; spur_data = 32'hDEAD_BEEF;
        tick();
        chk("spur_busy", 32'(s_busy), 32'd0);
        tick();
        chk("spur_if_rvalid", 32'(s_if_rv), 32'd0);
        chk("spur_d_rvalid", 32'(s_d_rv), 32'd0);
        chk("spur_if_rdata", s_if_rd, 32'h13);
        chk("spur_d_rdata", s_d_rd, 32'd0);
        chk("spur_busy2", 32'(s_busy), 32'd0);

        // starvation guard: both requesters held continuously
        if_req = 1; if_addr = 32'h0000_0200;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0300; d_wdata = 32'h0;
        ng = 0;
        for (int c = 0; c < 200 && ng < 20; c++) begin
            tick();
            if (s_if_gnt || s_d_gnt) begin
                chk("starve_order_if", 32'(s_if_gnt), 32'(ng % 5 == 4));
                ng++;
            end
        end
        chk("starve_count", 32'(ng), 32'd20);
        if_req = 0; d_req = 0;
        repeat (3) tick();

        // back-pressure
        ready_mode = 2;
        if_req = 1; if_addr = 32'h0000_0500;
        d_req = 1; d_we = 1; d_be = 4'b1100; d_addr = 32'h1234_5678; d_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_mem_req", 32'(s_mem_req), 32'd1);
            chk("bp_no_gnt", 32'(s_if_gnt | s_d_gnt), 32'd0);
        end
        ready_mode = 1;
        tick();
        chk("bp_d_gnt", 32'(s_d_gnt), 32'd1);
        chk("bp_if_gnt", 32'(s_if_gnt), 32'd0);
        chk("bp_mem_addr", s_mem_addr, 32'h1234_5678);
        chk("bp_mem_we", 32'(s_mem_we), 32'd1);
        chk("bp_mem_be", 32'(s_mem_be), 32'hC);
        chk("bp_mem_wdata", s_mem_wdata, 32'hCAFE_F00D);
        if_req = 0; d_req = 0;
        repeat (3) tick();

        // reset in the middle of a stalled load
        lat_min = 30; lat_max = 30;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h0000_0400;
        tick();
        chk("rst_pre_gnt", 32'(s_d_gnt), 32'd1);
        d_req = 0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("arst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_d_rdata", d_rdata, 32'd0);
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        lat_min = 1; lat_max = 1;
        if_req = 1; if_addr = 32'h0000_0100;
        tick();
        chk("post_rst_gnt", 32'(s_if_gnt), 32'd1);
        chk("post_rst_addr", s_mem_addr, 32'h100);
        if_req = 0;
        repeat (3) tick();

        // randomized traffic
        fixed_en = 0; lat_min = 1; lat_max = 3; ready_mode = 0;
        for (int c = 0; c < 800; c++) begin
            tick();
            if (if_req && s_if_gnt) if_req = 0;
            if (d_req && s_d_gnt) d_req = 0;
            if (!if_req && $urandom_range(2, 0) == 0) begin
                if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_req) begin
                d_we = ($urandom_range(1, 0) == 1);
                d_be = 4'($urandom_range(15, 1));
                d_addr = $urandom() & 32'hFFFF_FFFC;
                d_wdata = $urandom();
                if ($urandom_range(2, 0) == 0) d_req = 1;
            end
            if (!if_req && !d_req && !busy && $urandom_range(4, 0) == 0) begin
                spur_pulse = 1; spur_data = $urandom();
            end
        end
        if_req = 0; d_req = 0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Arbiter and sequencer for the single shared memory port of the multicycle OTTER. It shares the port between two requesters: instruction fetch (IF) and data load/store (D). It issues one transaction at a time and routes the registered response back to the requester that owns it. Data requests have priority, and a streak counter guarantees fetch progress. The block sits between the CPU control FSM and the memory/MMIO bus inside OTTER_Wrapper.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- MAX_STREAK, 4, max consecutive D grants while IF waits; legal range ≥1
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous, active-low
- IF_REQ  in  1  fetch request; held with IF_ADDR stable until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  one-cycle pulse: IF_RDATA valid
- IF_RDATA  out  DATA_W  fetched word
- D_REQ  in  1  data request; held with all D_* fields stable until D_GNT
- D_WE  in  1  1 = store, 0 = load
- D_BE  in  DATA_W/8  byte enables
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_GNT  out  1  data request accepted this cycle
- D_RVALID  out  1  one-cycle pulse: load data valid or store complete
- D_RDATA  out  DATA_W  load data; 0 on store completion
- MEM_REQ  out  1  request to memory
- MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA  out  1/DATA_W/8/ADDR_W/DATA_W  request fields; muxed from the selected requester
- MEM_READY  in  1  memory accepts MEM_REQ this cycle
- MEM_RVALID  in  1  completion of the outstanding transaction, for reads and writes
- MEM_RDATA  in  DATA_W  read data
- BUSY  out  1  transaction outstanding (state ≠ IDLE)

## Operation
- States: IDLE, WAIT_IF, WAIT_D. At most one outstanding transaction.
- IDLE:
  - Selection: D if D_REQ and (!IF_REQ or streak < MAX_STREAK), else IF if IF_REQ.
  - MEM_REQ = IF_REQ | D_REQ, combinational. MEM_* fields come from the selected requester.
  - When nothing is requested, MEM_* fields are 0.
  - Grant = MEM_REQ & MEM_READY. The selected requester's GNT is asserted combinationally in that cycle.
  - The FSM then moves to WAIT_IF or WAIT_D.
- WAIT_x:
  - MEM_REQ = 0; no grants.
  - On MEM_RVALID, capture the response and return to IDLE.
- Response register:
  - In the cycle after MEM_RVALID, x_RVALID = 1 and x_RDATA = captured MEM_RDATA, or 0 when the transaction was a store.
  - The other requester's RVALID stays 0 and its RDATA holds its last value.
- Streak counter, width $clog2(MAX_STREAK+1):
  - D grant with IF_REQ high: increment, saturating at MAX_STREAK.
  - D grant with IF_REQ low: clear to 0.
  - IF grant: clear to 0.
- MEM_RVALID in IDLE is spurious: ignored, no RVALID pulse, no state change.
- A requester dropping REQ before GNT is a protocol violation; the block simply re-arbitrates each IDLE cycle.

## Timing
- Reset values: state IDLE, streak 0, all outputs 0 (IF/D_RVALID, IF/D_RDATA, BUSY, and MEM_* combinationally 0 while no request).
- Reset mid-transaction returns to IDLE and abandons the transaction. Memory must be reset by the same RST_N, so no stale MEM_RVALID follows.
- Minimum request-to-response: grant in cycle N; MEM_RVALID at earliest N+1; x_RVALID at N+2.
- IDLE is re-entered the cycle after MEM_RVALID, the same cycle x_RVALID pulses. A new grant is possible in that cycle, so back-to-back throughput is one transaction per (memory latency + 1) cycles.
- Both REQs asserted with MEM_READY low: no grant, selection is re-evaluated every cycle, and the streak is unchanged.
- MEM_RVALID in the same cycle as the grant: not allowed, because memory latency is ≥1 by contract.

## Test plan
- Reset: assert RST_N=0 mid-WAIT_D with the memory model stalled → all outputs 0 and BUSY=0 asynchronously. After release, an IF_REQ to 0x100 is granted on the first cycle with MEM_READY.
- Single fetch: IF_REQ, IF_ADDR=0x0000_0040, memory latency 1, MEM_RDATA=0x0000_0013 → IF_GNT in cycle N, MEM_ADDR=0x40, IF_RVALID with IF_RDATA=0x13 at N+2, BUSY high N+1..N+1.
- Store: D_REQ, D_WE=1, D_BE=4'b0011, D_ADDR=0x1100_0020, D_WDATA=0xABCD_1234 → MEM_WE=1, MEM_BE=0011 and MEM_WDATA passed through; D_RVALID with D_RDATA=0 one cycle after MEM_RVALID; IF_RVALID stays 0.
- Priority and starvation guard: with MAX_STREAK=4, IF_REQ and D_REQ both held continuously → grant order D,D,D,D,IF,D,D,D,D,IF; no starvation across 20 transactions.
- Back-pressure: both REQs with MEM_READY=0 for 5 cycles → no GNT, MEM_REQ=1 throughout. When MEM_READY rises, D is granted (streak 0) and MEM_* fields carry the D_* values.
- Spurious completion: MEM_RVALID pulsed while in IDLE with MEM_RDATA=0xDEAD_BEEF → no RVALID pulse, RDATA outputs unchanged, state remains IDLE.
